// File: rtl/add_pkg.sv
// Shared types and constants for the single-bit full adder cell.
package add_pkg;

  localparam int LAT_MIN = 0;
  localparam int LAT_MAX = 3;

  typedef struct packed {
    logic cout;
    logic y;
  } add1_res_t;

endpackage

// File: rtl/add_1bit_core.sv
// Pure combinational full adder: sum and majority carry.
module add_1bit_core
  import add_pkg::*;
(
  input  logic      a,
  input  logic      b,
  input  logic      cin,
  output add1_res_t res
);

  assign res.y    = a ^ b ^ cin;
  assign res.cout = (a & b) | (a & cin) | (b & cin);

endmodule

// File: rtl/add_1bit.sv
// Full adder leaf cell with a LATENCY-deep valid-tagged pipeline and a saturating op counter.
// Optional: define ADD_1BIT_SELFCHECK_EN to add a sticky err flag driven by a reference pipeline.
module add_1bit
  import add_pkg::*;
#(
  parameter int LATENCY = 1,
  parameter int CNT_W   = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             a,
  input  logic             b,
  input  logic             cin,
  input  logic             in_valid,
  output logic             y,
  output logic             cout,
  output logic             out_valid,
  output logic [CNT_W-1:0] op_cnt
`ifdef ADD_1BIT_SELFCHECK_EN
  ,
  output logic             err
`endif
);

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (&v) ? v : v + CNT_W'(1);
  endfunction

  add1_res_t dp_res;

  add_1bit_core u_core (
    .a   (a),
    .b   (b),
    .cin (cin),
    .res (dp_res)
  );

`ifdef ADD_1BIT_SELFCHECK_EN
  add1_res_t ref_res;
  add1_res_t ref_out;

  add_1bit_core u_ref_core (
    .a   (a),
    .b   (b),
    .cin (cin),
    .res (ref_res)
  );
`endif

  if (LATENCY < LAT_MIN || LATENCY > LAT_MAX) begin : g_bad_latency
    $error("add_1bit: LATENCY out of range");
  end

  if (LATENCY == 0) begin : g_comb
    assign y         = dp_res.y;
    assign cout      = dp_res.cout;
    assign out_valid = in_valid;
`ifdef ADD_1BIT_SELFCHECK_EN
    assign ref_out   = ref_res;
`endif
  end else begin : g_pipe
    add1_res_t res_p [LATENCY];
    logic      vld_p [LATENCY];
`ifdef ADD_1BIT_SELFCHECK_EN
    add1_res_t ref_p [LATENCY];
`endif

    // Stage 0 captures the adder output; later stages shift it toward the outputs
    always_ff @(posedge clk) begin
      if (!rst_n) begin
        for (int i = 0; i < LATENCY; i++) begin
          res_p[i] <= '0;
          vld_p[i] <= 1'b0;
`ifdef ADD_1BIT_SELFCHECK_EN
          ref_p[i] <= '0;
`endif
        end
      end else begin
        res_p[0] <= dp_res;
        vld_p[0] <= in_valid;
`ifdef ADD_1BIT_SELFCHECK_EN
        ref_p[0] <= ref_res;
`endif
        for (int i = 1; i < LATENCY; i++) begin
          res_p[i] <= res_p[i-1];
          vld_p[i] <= vld_p[i-1];
`ifdef ADD_1BIT_SELFCHECK_EN
          ref_p[i] <= ref_p[i-1];
`endif
        end
      end
    end

    assign y         = res_p[LATENCY-1].y;
    assign cout      = res_p[LATENCY-1].cout;
    assign out_valid = vld_p[LATENCY-1];
`ifdef ADD_1BIT_SELFCHECK_EN
    assign ref_out   = ref_p[LATENCY-1];
`endif
  end

  // Gated on in_valid so X on the data inputs never reaches the counter
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      op_cnt <= '0;
    end else if (in_valid) begin
      op_cnt <= sat_inc(op_cnt);
    end
  end

`ifdef ADD_1BIT_SELFCHECK_EN
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      err <= 1'b0;
    end else if (out_valid && ({cout, y} != ref_out)) begin
      err <= 1'b1;
    end
  end
`endif

endmodule

// File: tb/tb_add_1bit.sv
// Directed bench for add_1bit at LATENCY 0/1/3 and a 2-bit saturating counter instance.
module tb_add_1bit;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst_n, a, b, cin, in_valid;
  logic y0, c0, v0, y1, c1, v1, y3, c3, v3, ys, cs, vs;
  logic [7:0] cnt0, cnt1, cnt3;
  logic [1:0] cnts;
`ifdef ADD_1BIT_SELFCHECK_EN
  logic err0, err1, err3, errs;
`endif

  add_1bit #(.LATENCY(0), .CNT_W(8)) u_l0 (
    .clk(clk), .rst_n(rst_n), .a(a), .b(b), .cin(cin), .in_valid(in_valid),
    .y(y0), .cout(c0), .out_valid(v0), .op_cnt(cnt0)
`ifdef ADD_1BIT_SELFCHECK_EN
    , .err(err0)
`endif
  );
  add_1bit #(.LATENCY(1), .CNT_W(8)) u_l1 (
    .clk(clk), .rst_n(rst_n), .a(a), .b(b), .cin(cin), .in_valid(in_valid),
    .y(y1), .cout(c1), .out_valid(v1), .op_cnt(cnt1)
`ifdef ADD_1BIT_SELFCHECK_EN
    , .err(err1)
`endif
  );
  add_1bit #(.LATENCY(3), .CNT_W(8)) u_l3 (
    .clk(clk), .rst_n(rst_n), .a(a), .b(b), .cin(cin), .in_valid(in_valid),
    .y(y3), .cout(c3), .out_valid(v3), .op_cnt(cnt3)
`ifdef ADD_1BIT_SELFCHECK_EN
    , .err(err3)
`endif
  );
  add_1bit #(.LATENCY(1), .CNT_W(2)) u_sat (
    .clk(clk), .rst_n(rst_n), .a(a), .b(b), .cin(cin), .in_valid(in_valid),
    .y(ys), .cout(cs), .out_valid(vs), .op_cnt(cnts)
`ifdef ADD_1BIT_SELFCHECK_EN
    , .err(errs)
`endif
  );

  // Hand-written truth table, {cout, y} indexed by {a, b, cin}
  logic [1:0] tt [8] = '{2'b00, 2'b01, 2'b01, 2'b10, 2'b01, 2'b10, 2'b10, 2'b11};

  int ncomp = 0;
  int nfail = 0;
  int n;
  int cnt_model;
  logic [1:0] h_res [80];
  bit         h_v   [80];
  bit         h_chk [80];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    ncomp++;
    assert (obs === exp) else begin
      nfail++;
      $error("FAIL %s step %0d: observed %0h expected %0h", tag, n, obs, exp);
    end
  endtask

  // One clock: drive inputs, check combinational outputs, clock, check registered outputs
  task automatic step(input logic [2:0] abc, input logic v, input logic r);
    {a, b, cin} = abc;
    in_valid = v;
    rst_n = r;
    #1;
    chk("l0_vld", {31'd0, v0}, {31'd0, v});
    if (!$isunknown(abc)) chk("l0_res", {30'd0, c0, y0}, {30'd0, tt[abc]});
    h_v[n]   = v && r;
    h_chk[n] = r ? v : 1'b1;
    h_res[n] = (r && !$isunknown(abc)) ? tt[abc] : 2'b00;
    if (!r) begin
      for (int k = 1; k <= 2; k++) begin
        h_v[n-k]   = 1'b0;
        h_chk[n-k] = 1'b1;
        h_res[n-k] = 2'b00;
      end
      cnt_model = 0;
    end else if (v) begin
      cnt_model++;
    end
    @(posedge clk);
    #1;
    chk("l1_vld", {31'd0, v1}, {31'd0, h_v[n]});
    if (h_chk[n]) chk("l1_res", {30'd0, c1, y1}, {30'd0, h_res[n]});
    chk("l3_vld", {31'd0, v3}, {31'd0, h_v[n-2]});
    if (h_chk[n-2]) chk("l3_res", {30'd0, c3, y3}, {30'd0, h_res[n-2]});
    chk("cnt_l0", {24'd0, cnt0}, (cnt_model > 255) ? 32'd255 : 32'(cnt_model));
    chk("cnt_l1", {24'd0, cnt1}, (cnt_model > 255) ? 32'd255 : 32'(cnt_model));
    chk("cnt_l3", {24'd0, cnt3}, (cnt_model > 255) ? 32'd255 : 32'(cnt_model));
    chk("cnt_sat", {30'd0, cnts}, (cnt_model > 3) ? 32'd3 : 32'(cnt_model));
`ifdef ADD_1BIT_SELFCHECK_EN
    chk("err_l0", {31'd0, err0}, 32'd0);
    chk("err_l1", {31'd0, err1}, 32'd0);
    chk("err_l3", {31'd0, err3}, 32'd0);
    chk("err_sat", {31'd0, errs}, 32'd0);
`endif
    n++;
  endtask

  initial begin
    for (int k = 0; k < 80; k++) begin
      h_v[k] = 1'b0;
      h_chk[k] = 1'b1;
      h_res[k] = 2'b00;
    end
    n = 2;
    cnt_model = 0;
    {a, b, cin} = 3'b000;
    in_valid = 1'b0;
    rst_n = 1'b0;

    // Reset
    step(3'b000, 1'b0, 1'b0);
    step(3'b000, 1'b0, 1'b0);

    // Exhaustive sweep, back to back
    for (int i = 0; i < 8; i++) step(3'(i), 1'b1, 1'b1);

    // Mid-stream reset with a valid op on the reset edge
    step(3'b111, 1'b1, 1'b1);
    step(3'b011, 1'b1, 1'b1);
    step(3'b110, 1'b1, 1'b1);
    step(3'b111, 1'b1, 1'b0);
    for (int i = 0; i < 4; i++) step(3'b000, 1'b0, 1'b1);

    // Valid gaps 1,0,1
    step(3'b100, 1'b1, 1'b1);
    step(3'b111, 1'b0, 1'b1);
    step(3'b001, 1'b1, 1'b1);
    for (int i = 0; i < 3; i++) step(3'b000, 1'b0, 1'b1);

    // Unknown data with in_valid low must not disturb the counters
    step(3'bxxx, 1'b0, 1'b1);
    step(3'b011, 1'b1, 1'b1);
    step(3'b101, 1'b1, 1'b1);
    for (int i = 0; i < 3; i++) step(3'b000, 1'b0, 1'b1);

`ifdef ADD_1BIT_SELFCHECK_EN
    // Corrupt the LATENCY=1 datapath for one cycle: err must set and stick until reset
    {a, b, cin} = 3'b000;
    in_valid = 1'b1;
    rst_n = 1'b1;
    force u_l1.dp_res = 2'b11;
    @(posedge clk);
    #1;
    release u_l1.dp_res;
    @(posedge clk);
    #1;
    chk("err_set", {31'd0, err1}, 32'd1);
    in_valid = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("err_sticky", {31'd0, err1}, 32'd1);
    rst_n = 1'b0;
    @(posedge clk);
    #1;
    chk("err_reset", {31'd0, err1}, 32'd0);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncomp, nfail);
    $finish;
  end

endmodule
